// File: rtl/lcd_pkg.sv
// Shared constants and types for the calculator character-LCD driver.
// Command bytes, ASCII codes, operator enum and the sequencing FSM states.
package lcd_pkg;

    localparam logic [7:0] FUNC_SET_1L = 8'h30;
    localparam logic [7:0] FUNC_SET_2L = 8'h38;
    localparam logic [7:0] DISP_ON     = 8'h0C;
    localparam logic [7:0] ENTRY_INC   = 8'h06;
    localparam logic [7:0] CLEAR       = 8'h01;
    localparam logic [7:0] LINE1_ADDR  = 8'h80;
    localparam logic [7:0] LINE2_ADDR  = 8'hC0;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_QMARK = 8'h3F;
    localparam logic [7:0] CH_E     = 8'h45;
    localparam logic [7:0] CH_R     = 8'h72;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MUL   = 8'h2A;
    localparam logic [7:0] CH_DIV   = 8'h2F;
    localparam logic [7:0] CH_ZERO  = 8'h30;

    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_code_e;

    typedef enum logic [3:0] {
        INIT, IDLE, ADDR1, A_DIG, OP, B_DIG, EQ, ADDR2, SIGN, R_DIG, PAD, FINISH
    } lcd_state_e;

    typedef enum logic [1:0] {W_IDLE, W_SETUP, W_EN} wr_phase_e;

    function automatic logic [7:0] op_char(input op_code_e op);
        case (op)
            OP_ADD:  op_char = CH_PLUS;
            OP_SUB:  op_char = CH_MINUS;
            OP_MUL:  op_char = CH_MUL;
            default: op_char = CH_DIV;
        endcase
    endfunction

    // Non-decimal nibbles render as '?' so corrupt BCD is visible on the panel.
    function automatic logic [7:0] digit_char(input logic [3:0] d);
        digit_char = (d > 4'd9) ? CH_QMARK : (CH_ZERO | {4'h0, d});
    endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// LCD tick divider plus 3-tick byte strobe (setup, enable high, enable low).
// Accepts a byte whenever req is high at an idle tick; ack marks the closing tick.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int TICK_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       rs,
    input  logic [7:0] byte_in,
    output logic       ack,
    output logic       tick,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    wr_phase_e     phase_q, phase_d;
    logic          rs_q, rs_d, en_q, en_d;
    logic [7:0]    data_q, data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= W_IDLE;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        tick    = (cnt_q == CW'(TICK_DIV - 1));
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        phase_d = phase_q;
        rs_d    = rs_q;
        en_d    = en_q;
        data_d  = data_q;
        ack     = 1'b0;
        if (tick) begin
            case (phase_q)
                W_IDLE: begin
                    if (req) begin
                        rs_d    = rs;
                        data_d  = byte_in;
                        en_d    = 1'b0;
                        phase_d = W_SETUP;
                    end
                end
                W_SETUP: begin
                    en_d    = 1'b1;
                    phase_d = W_EN;
                end
                W_EN: begin
                    en_d    = 1'b0;
                    ack     = 1'b1;
                    phase_d = W_IDLE;
                end
                default: phase_d = W_IDLE;
            endcase
        end
    end

    assign lcd_rs   = rs_q;
    assign lcd_en   = en_q;
    assign lcd_data = data_q;

endmodule

// File: rtl/lcd_expr_display.sv
// Character-LCD front end for the calculator: power-up init, then renders
// "A op B = R" on each start, padding every line so stale text is overwritten.
//   state  | meaning
//   INIT   | power-up commands, then Clear settle wait
//   IDLE   | waiting for start
//   ADDR1  | set DDRAM to line 1
//   A_DIG  | operand A digits, MSB first, leading zeros suppressed
//   OP     | operator character
//   B_DIG  | operand B digits
//   EQ     | '='
//   ADDR2  | set DDRAM to line 2 (TWO_LINE only)
//   SIGN   | '-' for negative results
//   R_DIG  | result digits, or "Err"
//   PAD    | spaces to fill the current line
//   FINISH | pulse done
module lcd_expr_display
    import lcd_pkg::*;
#(
    parameter int OPD_DIGITS = 4,
    parameter int RES_DIGITS = 8,
    parameter int TICK_DIV   = 50000,
    parameter int LINE_CHARS = 16,
    parameter int TWO_LINE   = 0,
    parameter int CLEAR_WAIT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [4*OPD_DIGITS-1:0] a_bcd,
    input  logic [4*OPD_DIGITS-1:0] b_bcd,
    input  logic [1:0]              op_code,
    input  logic [4*RES_DIGITS-1:0] res_bcd,
    input  logic                    res_neg,
    input  logic                    err,
    output logic                    busy,
    output logic                    done,
    output logic                    lcd_rs,
    output logic                    lcd_en,
    output logic                    lcd_rw,
    output logic [7:0]              lcd_data
);

    localparam int MAXD = (OPD_DIGITS > RES_DIGITS) ? OPD_DIGITS : RES_DIGITS;
    localparam int DW   = $clog2((MAXD > 3) ? MAXD : 3);
    localparam int CCW  = $clog2(LINE_CHARS + 1);
    localparam int IW   = $clog2(CLEAR_WAIT + 5);
    localparam logic [CCW-1:0] LINE_MAX = CCW'(LINE_CHARS);

    lcd_state_e              state_q, state_d;
    logic [IW-1:0]           init_idx_q, init_idx_d;
    logic [DW-1:0]           dig_idx_q, dig_idx_d;
    logic [CCW-1:0]          char_cnt_q, char_cnt_d;
    logic                    line2_q, line2_d;
    logic [4*OPD_DIGITS-1:0] a_q, a_d, b_q, b_d;
    logic [4*RES_DIGITS-1:0] r_q, r_d;
    op_code_e                op_q, op_d;
    logic                    neg_q, neg_d, err_q, err_d;

    logic          req, rs, ack, tick, emit, adv;
    logic [7:0]    byte_out;
    logic [3:0]    a_nib, b_nib, r_nib;
    logic [DW-1:0] msd_a, msd_b, msd_r, res_idx;
    lcd_state_e    res_state, pad_exit;

    lcd_byte_writer #(.TICK_DIV(TICK_DIV)) u_writer (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .rs       (rs),
        .byte_in  (byte_out),
        .ack      (ack),
        .tick     (tick),
        .lcd_rs   (lcd_rs),
        .lcd_en   (lcd_en),
        .lcd_data (lcd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            init_idx_q <= '0;
            dig_idx_q  <= '0;
            char_cnt_q <= '0;
            line2_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            r_q        <= '0;
            op_q       <= OP_ADD;
            neg_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            dig_idx_q  <= dig_idx_d;
            char_cnt_q <= char_cnt_d;
            line2_q    <= line2_d;
            a_q        <= a_d;
            b_q        <= b_d;
            r_q        <= r_d;
            op_q       <= op_d;
            neg_q      <= neg_d;
            err_q      <= err_d;
        end
    end

    // Highest non-zero digit per field, and the digit currently being rendered.
    always_comb begin
        msd_a = '0;
        msd_b = '0;
        msd_r = '0;
        a_nib = 4'h0;
        b_nib = 4'h0;
        r_nib = 4'h0;
        for (int i = 0; i < OPD_DIGITS; i++) begin
            if (a_q[i*4 +: 4] != 4'h0) msd_a = DW'(i);
            if (b_q[i*4 +: 4] != 4'h0) msd_b = DW'(i);
            if (int'(dig_idx_q) == i) begin
                a_nib = a_q[i*4 +: 4];
                b_nib = b_q[i*4 +: 4];
            end
        end
        for (int i = 0; i < RES_DIGITS; i++) begin
            if (r_q[i*4 +: 4] != 4'h0) msd_r = DW'(i);
            if (int'(dig_idx_q) == i) r_nib = r_q[i*4 +: 4];
        end
        res_state = err_q ? R_DIG : (neg_q ? SIGN : R_DIG);
        res_idx   = err_q ? DW'(2) : msd_r;
        pad_exit  = ((TWO_LINE != 0) && !line2_q) ? ADDR2 : FINISH;
    end

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        dig_idx_d  = dig_idx_q;
        char_cnt_d = char_cnt_q;
        line2_d    = line2_q;
        a_d        = a_q;
        b_d        = b_q;
        r_d        = r_q;
        op_d       = op_q;
        neg_d      = neg_q;
        err_d      = err_q;
        req        = 1'b0;
        rs         = 1'b1;
        byte_out   = CH_SPACE;
        // Characters past the line end are skipped without touching the bus.
        emit       = (char_cnt_q < LINE_MAX);
        adv        = emit ? ack : 1'b1;

        case (state_q)
            INIT: begin
                if (init_idx_q < IW'(4)) begin
                    req = 1'b1;
                    rs  = 1'b0;
                    if (init_idx_q == IW'(0))      byte_out = (TWO_LINE != 0) ? FUNC_SET_2L : FUNC_SET_1L;
                    else if (init_idx_q == IW'(1)) byte_out = DISP_ON;
                    else if (init_idx_q == IW'(2)) byte_out = ENTRY_INC;
                    else                           byte_out = CLEAR;
                    if (ack) begin
                        if (init_idx_q == IW'(3) && CLEAR_WAIT == 0) state_d = IDLE;
                        else init_idx_d = init_idx_q + 1'b1;
                    end
                end else if (tick) begin
                    if (init_idx_q >= IW'(3 + CLEAR_WAIT)) state_d = IDLE;
                    else init_idx_d = init_idx_q + 1'b1;
                end
            end
            IDLE: begin
                if (start) begin
                    a_d     = a_bcd;
                    b_d     = b_bcd;
                    r_d     = res_bcd;
                    op_d    = op_code_e'(op_code);
                    neg_d   = res_neg;
                    err_d   = err;
                    state_d = ADDR1;
                end
            end
            ADDR1, ADDR2: begin
                req      = 1'b1;
                rs       = 1'b0;
                byte_out = (state_q == ADDR1) ? LINE1_ADDR : LINE2_ADDR;
                if (ack) begin
                    char_cnt_d = '0;
                    line2_d    = (state_q == ADDR2);
                    state_d    = (state_q == ADDR1) ? A_DIG : res_state;
                    dig_idx_d  = (state_q == ADDR1) ? msd_a : res_idx;
                end
            end
            A_DIG, B_DIG: begin
                req      = emit;
                byte_out = digit_char((state_q == A_DIG) ? a_nib : b_nib);
                if (adv) begin
                    if (dig_idx_q == '0) state_d = (state_q == A_DIG) ? OP : EQ;
                    else dig_idx_d = dig_idx_q - 1'b1;
                end
            end
            OP: begin
                req      = emit;
                byte_out = op_char(op_q);
                if (adv) begin
                    state_d   = B_DIG;
                    dig_idx_d = msd_b;
                end
            end
            EQ: begin
                req      = emit;
                byte_out = CH_EQ;
                if (adv) begin
                    state_d   = (TWO_LINE != 0) ? PAD : res_state;
                    dig_idx_d = res_idx;
                end
            end
            SIGN: begin
                req      = emit;
                byte_out = CH_MINUS;
                if (adv) begin
                    state_d   = R_DIG;
                    dig_idx_d = msd_r;
                end
            end
            R_DIG: begin
                req = emit;
                if (err_q) byte_out = (dig_idx_q == DW'(2)) ? CH_E : CH_R;
                else       byte_out = digit_char(r_nib);
                if (adv) begin
                    if (dig_idx_q == '0) state_d = PAD;
                    else dig_idx_d = dig_idx_q - 1'b1;
                end
            end
            PAD: begin
                req = emit;
                // Leave on the closing tick of the last space so done follows it directly.
                if (!emit || (ack && char_cnt_q == LINE_MAX - 1'b1)) state_d = pad_exit;
            end
            FINISH:  state_d = IDLE;
            default: state_d = INIT;
        endcase

        if (req && rs && ack) char_cnt_d = char_cnt_q + 1'b1;
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == FINISH);
    assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_expr_display.sv
// Randomized bench for lcd_expr_display: a single-line 4-digit instance and a
// two-line 8-digit instance, checked against a string-level model of the screen.
module tb_lcd_expr_display;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start0, neg0, err0, busy0, done0, rs0, en0, rw0;
    logic [15:0] a0, b0;
    logic [1:0]  op0;
    logic [31:0] r0;
    logic [7:0]  d0;
    logic        start1, neg1, err1, busy1, done1, rs1, en1, rw1;
    logic [31:0] a1, b1, r1;
    logic [1:0]  op1;
    logic [7:0]  d1;

    lcd_expr_display #(.OPD_DIGITS(4), .RES_DIGITS(8), .TICK_DIV(4), .LINE_CHARS(16),
                       .TWO_LINE(0), .CLEAR_WAIT(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a_bcd(a0), .b_bcd(b0), .op_code(op0),
        .res_bcd(r0), .res_neg(neg0), .err(err0), .busy(busy0), .done(done0),
        .lcd_rs(rs0), .lcd_en(en0), .lcd_rw(rw0), .lcd_data(d0));

    lcd_expr_display #(.OPD_DIGITS(8), .RES_DIGITS(8), .TICK_DIV(4), .LINE_CHARS(16),
                       .TWO_LINE(1), .CLEAR_WAIT(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a_bcd(a1), .b_bcd(b1), .op_code(op1),
        .res_bcd(r1), .res_neg(neg1), .err(err1), .busy(busy1), .done(done1),
        .lcd_rs(rs1), .lcd_en(en1), .lcd_rw(rw1), .lcd_data(d1));

    int n_chk = 0;
    int n_pass = 0;
    logic [8:0] cap0[$], cap1[$], exp_q[$];
    int ndone0 = 0, ndone1 = 0;
    int hi0 = 0, hi1 = 0;
    logic prev0 = 1'b0, prev1 = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Byte capture on enable rise, enable width per byte, done pulse count.
    always @(posedge clk) begin
        #1;
        if (en0 && !prev0) cap0.push_back({rs0, d0});
        if (en1 && !prev1) cap1.push_back({rs1, d1});
        if (!en0 && prev0 && rst_n) chk("en_width0", hi0, 4);
        if (!en1 && prev1 && rst_n) chk("en_width1", hi1, 4);
        hi0 = (en0 && rst_n) ? hi0 + 1 : 0;
        hi1 = (en1 && rst_n) ? hi1 + 1 : 0;
        prev0 = en0;
        prev1 = en1;
        if (done0) ndone0++;
        if (done1) ndone1++;
    end

    function automatic string num_str(input logic [31:0] v, input int nd);
        int hi = -1;
        string s = "";
        logic [3:0] d;
        for (int i = 0; i < nd; i++) if (v[4*i +: 4] != 4'h0) hi = i;
        if (hi < 0) return "0";
        for (int i = hi; i >= 0; i--) begin
            d = v[4*i +: 4];
            s = (d > 4'd9) ? {s, "?"} : {s, $sformatf("%0d", d)};
        end
        return s;
    endfunction

    task automatic push_line(input string line);
        logic [7:0] ch;
        for (int i = 0; i < 16; i++) begin
            ch = (i < line.len()) ? line[i] : 8'h20;
            exp_q.push_back({1'b1, ch});
        end
    endtask

    task automatic model(input int nd, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [31:0] r, input logic neg,
                         input logic err, input bit two);
        string ops = "+-*/";
        string res, l1;
        res = err ? "Err" : {neg ? "-" : "", num_str(r, 8)};
        l1  = {num_str(a, nd), ops.substr(int'(op), int'(op)), num_str(b, nd), "="};
        exp_q.delete();
        exp_q.push_back(9'h080);
        if (two) begin
            push_line(l1);
            exp_q.push_back(9'h0C0);
            push_line(res);
        end else begin
            push_line({l1, res});
        end
    endtask

    task automatic cmp_stream(input int which, input string tag);
        int n;
        logic [8:0] g;
        n = which ? cap1.size() : cap0.size();
        chk({tag, "_len"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            g = which ? cap1[i] : cap0[i];
            chk($sformatf("%s_b%0d", tag, i), int'(g), int'(exp_q[i]));
        end
    endtask

    function automatic logic [31:0] rnd_bcd(input int nd);
        logic [31:0] v = '0;
        logic [3:0] d;
        int lz = $urandom_range(0, nd);
        for (int i = 0; i < nd; i++) begin
            d = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            if (i >= nd - lz) d = 4'h0;
            v[4*i +: 4] = d;
        end
        return v;
    endfunction

    task automatic wait_init(input string tag);
        int n = 0;
        bit fell = 0;
        while (n < 500 && !fell) begin
            @(posedge clk); #1;
            n++;
            if (!busy0) fell = 1;
        end
        chk({tag, "_busy_cycles"}, n, 56);
        chk({tag, "_busy1"}, int'(busy1), 0);
        exp_q = '{9'h030, 9'h00C, 9'h006, 9'h001};
        cmp_stream(0, {tag, "_cmd0"});
        exp_q = '{9'h038, 9'h00C, 9'h006, 9'h001};
        cmp_stream(1, {tag, "_cmd1"});
    endtask

    task automatic do_refresh(input int which, input int restart_at, input bit start_on_done,
                              output int lat);
        bit got = 0;
        cap0.delete(); cap1.delete();
        ndone0 = 0; ndone1 = 0;
        @(negedge clk);
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        lat = 0;
        while (lat < 3000 && !got) begin
            @(posedge clk); #1;
            lat++;
            if (which ? done1 : done0) got = 1;
            else if (lat == restart_at) begin
                if (which) start1 = 1'b1; else start0 = 1'b1;
            end else begin
                start0 = 1'b0; start1 = 1'b0;
            end
        end
        start0 = 1'b0; start1 = 1'b0;
        chk("done_seen", int'(got), 1);
        if (start_on_done) begin
            if (which) start1 = 1'b1; else start0 = 1'b1;
            @(posedge clk); #1;
            start0 = 1'b0; start1 = 1'b0;
        end
        repeat (12) @(posedge clk);
        #1;
        chk("done_once", which ? ndone1 : ndone0, 1);
        chk("busy_after", int'(which ? busy1 : busy0), 0);
    endtask

    initial begin
        int lat;
        int nb;
        logic [31:0] t;
        rst_n = 1'b0;
        {start0, neg0, err0, a0, b0, op0, r0} = '0;
        {start1, neg1, err1, a1, b1, op1, r1} = '0;
        repeat (3) @(negedge clk);
        chk("rst_rs", int'(rs0), 0);
        chk("rst_en", int'(en0), 0);
        chk("rst_data", int'(d0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_busy", int'(busy0), 1);
        chk("rst_rw", int'(rw0), 0);
        rst_n = 1'b1;
        wait_init("init");

        // Basic refresh, with a second start mid-refresh that must be dropped.
        a0 = 16'h0012; b0 = 16'h0003; op0 = 2'd0; r0 = 32'h15; neg0 = 0; err0 = 0;
        do_refresh(0, 60, 1'b0, lat);
        chk("basic_ticks", (lat + 3) / 4, 51);
        model(4, {16'h0, a0}, {16'h0, b0}, op0, r0, neg0, err0, 1'b0);
        cmp_stream(0, "basic");

        // Zero operand, invalid nibble, start coinciding with done.
        a0 = 16'h0000; b0 = 16'h00A7; op0 = 2'd3; r0 = 32'h0;
        do_refresh(0, 0, 1'b1, lat);
        model(4, {16'h0, a0}, {16'h0, b0}, op0, r0, neg0, err0, 1'b0);
        cmp_stream(0, "zero");

        for (int k = 0; k < 10; k++) begin
            t = rnd_bcd(4); a0 = t[15:0];
            t = rnd_bcd(4); b0 = t[15:0];
            op0 = 2'($urandom_range(0, 3));
            r0 = rnd_bcd(8);
            neg0 = 1'($urandom_range(0, 1));
            err0 = ($urandom_range(0, 4) == 0);
            do_refresh(0, 0, 1'b0, lat);
            model(4, {16'h0, a0}, {16'h0, b0}, op0, r0, neg0, err0, 1'b0);
            cmp_stream(0, $sformatf("rnd0_%0d", k));
        end

        // Two-line error case, then a line-1 overflow with 8-digit operands.
        a1 = 32'h9999; b1 = 32'h9999; op1 = 2'd2; r1 = 32'h1234; neg1 = 1; err1 = 1;
        do_refresh(1, 0, 1'b0, lat);
        chk("err_ticks", (lat + 3) / 4, 102);
        model(8, a1, b1, op1, r1, neg1, err1, 1'b1);
        cmp_stream(1, "err2l");

        a1 = 32'h12345678; b1 = 32'h87654321; op1 = 2'd1; r1 = 32'h0; neg1 = 0; err1 = 0;
        do_refresh(1, 0, 1'b0, lat);
        model(8, a1, b1, op1, r1, neg1, err1, 1'b1);
        cmp_stream(1, "trunc");

        for (int k = 0; k < 6; k++) begin
            a1 = rnd_bcd(8); b1 = rnd_bcd(8);
            op1 = 2'($urandom_range(0, 3));
            r1 = rnd_bcd(8);
            neg1 = 1'($urandom_range(0, 1));
            err1 = ($urandom_range(0, 4) == 0);
            do_refresh(1, 0, 1'b0, lat);
            model(8, a1, b1, op1, r1, neg1, err1, 1'b1);
            cmp_stream(1, $sformatf("rnd1_%0d", k));
        end

        // Reset at the fifth byte of a refresh.
        cap0.delete(); cap1.delete();
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        nb = 0;
        while (cap0.size() < 5 && nb < 2000) begin
            @(posedge clk); #1;
            nb++;
        end
        chk("byte5_reached", cap0.size(), 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", int'(en0), 0);
        chk("mid_rst_rs", int'(rs0), 0);
        chk("mid_rst_data", int'(d0), 0);
        chk("mid_rst_busy", int'(busy0), 1);
        chk("mid_rst_done", int'(done0), 0);
        repeat (2) @(negedge clk);
        cap0.delete(); cap1.delete();
        rst_n = 1'b1;
        wait_init("reinit");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
